// File: rtl/k16_mem_pkg.sv
// Shared constants and FSM state encoding for the K16 memory arbiter.
package k16_mem_pkg;

    localparam int unsigned K16_ADDR_W = 16;
    localparam int unsigned K16_DATA_W = 16;

    // Arbiter state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_CPU       = 2'd0;
    localparam arb_state_t ARB_HOLD_WAIT = 2'd1;
    localparam arb_state_t ARB_VIDEO     = 2'd2;
    localparam arb_state_t ARB_TAIL      = 2'd3;

endpackage

// File: rtl/k16_mem_arbiter.sv
// K16 RAM arbiter: shares one synchronous single-port RAM between the CPU bus and the video
// line fetcher. Video has priority; the CPU is stalled via cpu_hold once it leaves its bus cycle.
// Optional build macro K16_ARB_FAIRNESS_EN caps video bursts at MAX_BURST words and then
// guarantees the CPU CPU_SLOT cycles before video may re-arbitrate.
module k16_mem_arbiter
    import k16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = K16_ADDR_W,
    parameter int unsigned DATA_W    = K16_DATA_W,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CPU_SLOT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    input  logic              cpu_busy,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    logic       rvalid_q;
    logic       slot_busy;   // CPU slot still running; video requests ignored
    logic       burst_done;  // this ack is the last one allowed in the burst

`ifdef K16_ARB_FAIRNESS_EN
    localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned SLOT_W  = (CPU_SLOT > 1) ? $clog2(CPU_SLOT) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    // The final slot cycle is also the arbitration cycle, hence CPU_SLOT - 1.
    localparam logic [SLOT_W-1:0]  SLOT_LOAD  = (CPU_SLOT > 0) ? SLOT_W'(CPU_SLOT - 1) : '0;

    logic [BURST_W-1:0] burst_q, burst_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    assign slot_busy  = (slot_q != '0);
    assign burst_done = vid_ack && (burst_q == BURST_LAST);

    // Burst counter clears in TAIL; slot counter loads in TAIL and drains in CPU.
    always_comb begin
        burst_d = burst_q;
        slot_d  = slot_q;
        if (state_q == ARB_TAIL) begin
            burst_d = '0;
            slot_d  = SLOT_LOAD;
        end else begin
            if (vid_ack) begin
                burst_d = burst_q + 1'b1;
            end
            if (state_q == ARB_CPU && slot_busy) begin
                slot_d = slot_q - 1'b1;
            end
        end
    end

    // Fairness counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
            slot_q  <= '0;
        end else begin
            burst_q <= burst_d;
            slot_q  <= slot_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_BURST[0], CPU_SLOT[0]};
    assign slot_busy  = 1'b0;
    assign burst_done = 1'b0;
`endif

    // Next-state logic; a dropped request in HOLD_WAIT takes precedence over cpu_busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_CPU: begin
                if (vid_req && !slot_busy) state_d = ARB_HOLD_WAIT;
            end
            ARB_HOLD_WAIT: begin
                if (!vid_req)       state_d = ARB_CPU;
                else if (!cpu_busy) state_d = ARB_VIDEO;
            end
            ARB_VIDEO: begin
                if (!vid_req || burst_done) state_d = ARB_TAIL;
            end
            default: state_d = ARB_CPU;
        endcase
    end

    // State and read-valid registers; reset drops any outstanding video word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_CPU;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= vid_ack;
        end
    end

    // RAM address/write mux and handshake outputs.
    always_comb begin
        mem_addr = (state_q == ARB_VIDEO) ? vid_addr : cpu_addr;
        // The CPU keeps the bus through HOLD_WAIT so an in-flight write completes.
        mem_we   = cpu_write && (state_q == ARB_CPU || state_q == ARB_HOLD_WAIT);
        cpu_hold = (state_q != ARB_CPU);
        vid_ack  = (state_q == ARB_VIDEO) && vid_req && !reset;
    end

    assign mem_wdata  = cpu_wdata;
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;
    assign vid_rvalid = rvalid_q;

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// Self-checking bench for k16_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Video read data is checked by a scoreboard; the fairness scenario runs only when
// K16_ARB_FAIRNESS_EN is defined.
module tb_k16_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_write;
    logic        cpu_busy;
    logic        cpu_hold;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic        vid_rvalid;
    logic [15:0] vid_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_total = 0;
    logic [15:0] sb[$];
    logic [15:0] ram [0:65535];

    k16_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .cpu_busy   (cpu_busy),
        .cpu_hold   (cpu_hold),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Preloaded video pattern.
    function automatic logic [15:0] exp_word(input logic [15:0] a);
        return 16'hA000 + (a - 16'h0100) * 16'h0011;
    endfunction

    // Scoreboard monitor: every rvalid must match the oldest accepted video word.
    always @(negedge clk) begin
        if (vid_rvalid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_unexpected: got rvalid=1 data %h expected no rvalid", vid_rdata);
            end else begin
                check("vid_rdata", vid_rdata, sb.pop_front());
            end
        end
        if (vid_ack) ack_total++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish by 100000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Video fetcher model: requests n words from start, advancing the address after each ack.
    task automatic run_video(input logic [15:0] start, input int n, input int busy_cycles,
                             input bit write_all, input bit keep_req,
                             output int first_ack, output int acks);
        logic got;
        vid_addr  = start;
        vid_req   = 1'b1;
        acks      = 0;
        first_ack = -1;
        for (int g = 0; g < 60 && acks < n; g++) begin
            cpu_busy  = (g < busy_cycles);
            cpu_write = write_all;
            cpu_addr  = 16'h0200 + g[15:0];
            cpu_wdata = 16'hBEE0 + g[15:0];
            @(negedge clk);
            got = vid_ack;
            if (got) begin
                if (first_ack < 0) first_ack = g;
                check("vid_mem_addr", mem_addr, vid_addr);
                check("vid_mem_we", mem_we, 1'b0);
                sb.push_back(exp_word(vid_addr));
                acks++;
            end
            step();
            if (got) vid_addr = vid_addr + 16'd1;
        end
        if (acks < n) check("vid_ack_timeout", acks, n);
        cpu_write = 1'b0;
        cpu_busy  = 1'b0;
        if (!keep_req) vid_req = 1'b0;
    endtask

    initial begin
        int fa;
        int acks;
        int a0;
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_busy = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_ack", vid_ack, 1'b0);
        check("rst_rvalid", vid_rvalid, 1'b0);
        step();

        // 1: plain CPU write.
        cpu_addr = 16'h0010; cpu_wdata = 16'h1234; cpu_write = 1'b1;
        @(negedge clk);
        check("t1_we", mem_we, 1'b1);
        check("t1_addr", mem_addr, 16'h0010);
        check("t1_wdata", mem_wdata, 16'h1234);
        check("t1_hold", cpu_hold, 1'b0);
        step();
        cpu_write = 1'b0;
        check("t1_ram", ram[16'h0010], 16'h1234);

        for (int i = 0; i < 8; i++) cpu_wr(16'h0100 + i[15:0], exp_word(16'h0100 + i[15:0]));
        for (int i = 4; i < 8; i++) cpu_wr(16'h0200 + i[15:0], 16'h5555);
        idle(2);

        // 2: 4-word burst with idle CPU.
        vid_addr = 16'h0100; vid_req = 1'b1;
        @(negedge clk);
        check("t2_hold_c0", cpu_hold, 1'b0);
        step();
        @(negedge clk);
        check("t2_hold_c1", cpu_hold, 1'b1);
        check("t2_ack_c1", vid_ack, 1'b0);
        step();
        run_video(16'h0100, 4, 0, 1'b0, 1'b0, fa, acks);
        check("t2_first_ack", fa, 0);
        check("t2_acks", acks, 4);
        @(negedge clk);
        check("t2_hold_drop1", cpu_hold, 1'b1);
        step();
        @(negedge clk);
        check("t2_hold_tail", cpu_hold, 1'b1);
        check("t2_we_tail", mem_we, 1'b0);
        step();
        @(negedge clk);
        check("t2_hold_cpu", cpu_hold, 1'b0);
        step();
        check("t2_sb_empty", sb.size(), 0);
        idle(3);

        // 3: video request while the CPU is busy for 3 cycles and writing throughout.
        run_video(16'h0100, 2, 3, 1'b1, 1'b0, fa, acks);
        check("t3_first_ack", fa, 4);
        check("t3_acks", acks, 2);
        idle(3);
        check("t3_ram0", ram[16'h0200], 16'hBEE0);
        check("t3_ram2", ram[16'h0202], 16'hBEE2);
        check("t3_ram3", ram[16'h0203], 16'hBEE3);
        check("t3_ram4_kept", ram[16'h0204], 16'h5555);
        check("t3_ram5_kept", ram[16'h0205], 16'h5555);
        check("t3_sb_empty", sb.size(), 0);
        idle(2);

        // 5: reset in the middle of a burst.
        vid_addr = 16'h0100; vid_req = 1'b1;
        idle(2);
        @(negedge clk);
        check("t5_ack_video", vid_ack, 1'b1);
        sb.push_back(exp_word(16'h0100));
        step();
        vid_addr = 16'h0101;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_hold", cpu_hold, 1'b0);
        check("t5_ack", vid_ack, 1'b0);
        check("t5_rvalid", vid_rvalid, 1'b0);
        check("t5_addr", mem_addr, cpu_addr);
        step();
        vid_req = 1'b0;
        idle(3);
        check("t5_sb_empty", sb.size(), 0);

        // 6: request withdrawn during HOLD_WAIT while the CPU writes.
        a0 = ack_total;
        cpu_busy = 1'b1; vid_req = 1'b1;
        cpu_addr = 16'h0300; cpu_wdata = 16'h7777; cpu_write = 1'b1;
        step();
        vid_req = 1'b0; cpu_addr = 16'h0301; cpu_wdata = 16'h8888;
        @(negedge clk);
        check("t6_hold_hw", cpu_hold, 1'b1);
        check("t6_we_hw", mem_we, 1'b1);
        check("t6_ack_hw", vid_ack, 1'b0);
        step();
        cpu_write = 1'b0; cpu_busy = 1'b0;
        @(negedge clk);
        check("t6_hold_cpu", cpu_hold, 1'b0);
        step();
        check("t6_ram0", ram[16'h0300], 16'h7777);
        check("t6_ram1", ram[16'h0301], 16'h8888);
        check("t6_no_acks", ack_total - a0, 0);
        idle(2);

`ifdef K16_ARB_FAIRNESS_EN
        // 4: continuous request is capped at 8 words, then 2 CPU cycles.
        run_video(16'h0100, 8, 0, 1'b0, 1'b1, fa, acks);
        check("t4_acks", acks, 8);
        @(negedge clk);
        check("t4_hold_tail", cpu_hold, 1'b1);
        check("t4_ack_tail", vid_ack, 1'b0);
        step();
        @(negedge clk);
        check("t4_hold_slot1", cpu_hold, 1'b0);
        step();
        @(negedge clk);
        check("t4_hold_slot2", cpu_hold, 1'b0);
        step();
        @(negedge clk);
        check("t4_hold_again", cpu_hold, 1'b1);
        vid_req = 1'b0;
        step();
        idle(3);
        check("t4_sb_empty", sb.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
